rca_lsu_responder: RTL and testbench

Memory-side responder for the RCA load/store path. Accepts one load or store request at a time from the RCA LSQ over the `rca_lsu_interface` signal set and converts it into a word-aligned memory bus access with byte enables. Returns load results to the LSQ strictly in request order, sign- or zero-extended per `fn3`. Sits between the RCA LSQ and the data memory port muxed in while `rca_lsu_lock` is held.

---
 rtl/rca_lsu_responder.sv | 212 +++++++++++++++++++++
 tb/tb_rca_lsu_responder.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rca_lsu_responder.sv
// Memory-side responder for the RCA load/store path: one request buffer,
// word-aligned bus issue with byte enables, in-order load return.
module rca_lsu_responder #(
    parameter int XLEN            = 32,
    parameter int MAX_OUTSTANDING = 4,
    parameter int ID_W            = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            new_request,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [2:0]      fn3,
    input  logic            load,
    input  logic            store,
    input  logic [ID_W-1:0] id,
    output logic            lsu_ready,
    output logic            load_complete,
    output logic [XLEN-1:0] load_data,
    output logic [ID_W-1:0] load_id,
    output logic            misaligned_error,
    output logic            busy,
    output logic            mem_request,
    output logic [XLEN-1:0] mem_addr,
    output logic            mem_we,
    output logic [3:0]      mem_be,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_ack,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata
);
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    logic            buf_valid;
    logic [XLEN-1:0] buf_addr;
    logic [XLEN-1:0] buf_data;
    logic [2:0]      buf_fn3;
    logic            buf_load;
    logic            buf_store;
    logic [ID_W-1:0] buf_id;

    logic [ID_W-1:0] q_id  [MAX_OUTSTANDING];
    logic [2:0]      q_fn3 [MAX_OUTSTANDING];
    logic [1:0]      q_off [MAX_OUTSTANDING];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            fifo_full;
    logic            fifo_empty;
    logic            seen_push;

    logic            lc_q;
    logic [XLEN-1:0] data_q;
    logic [ID_W-1:0] id_q;

    logic [1:0]      off;
    logic            width_ok;
    logic            legal;
    logic            push;
    logic            pop;
    logic            accept_mem;
    logic            st_err_fire;
    logic            ld_err_fire;
    logic [7:0]      head_byte;
    logic [15:0]     head_half;
    logic [XLEN-1:0] ext_data;

    assign fifo_full  = (count == CW'(MAX_OUTSTANDING));
    assign fifo_empty = (count == '0);
    assign pop        = mem_rvalid & ~fifo_empty;
    assign off        = buf_addr[1:0];

    always_comb begin
        width_ok = 1'b0;
        case (buf_fn3)
            3'b000:  width_ok = 1'b1;
            3'b001:  width_ok = ~off[0];
            3'b010:  width_ok = (off == 2'b00);
            3'b100:  width_ok = buf_load;
            3'b101:  width_ok = buf_load & ~off[0];
            default: width_ok = 1'b0;
        endcase
    end

    assign legal = (buf_load ^ buf_store) & width_ok;

    // A load may take the slot freed by a same-cycle pop.
    assign mem_request = buf_valid & legal & (buf_store | ~fifo_full | pop);
    assign accept_mem  = mem_request & mem_ack;
    assign push        = accept_mem & buf_load;

    // Error loads wait for all older results so completions stay in order.
    assign st_err_fire = buf_valid & ~legal & ~buf_load;
    assign ld_err_fire = buf_valid & ~legal & buf_load & fifo_empty & ~lc_q;

    assign lsu_ready        = ~buf_valid;
    assign misaligned_error = st_err_fire | ld_err_fire;
    assign mem_addr         = {buf_addr[XLEN-1:2], 2'b00};
    assign mem_we           = buf_valid & legal & buf_store;

    always_comb begin
        mem_be    = 4'b0000;
        mem_wdata = buf_data;
        if (buf_valid & legal) begin
            mem_be = 4'b1111;
            if (buf_store) begin
                case (buf_fn3[1:0])
                    2'b00: begin
                        mem_be    = 4'b0001 << off;
                        mem_wdata = {4{buf_data[7:0]}};
                    end
                    2'b01: begin
                        mem_be    = 4'b0011 << off;
                        mem_wdata = {2{buf_data[15:0]}};
                    end
                    default: mem_be = 4'b1111;
                endcase
            end
        end
    end

    assign load_complete = lc_q | ld_err_fire;
    assign load_data     = ld_err_fire ? '0 : data_q;
    assign load_id       = ld_err_fire ? buf_id : id_q;
    assign busy          = buf_valid | ~fifo_empty | load_complete;

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_valid <= 1'b0;
        end else if (lsu_ready & new_request) begin
            buf_valid <= 1'b1;
        end else if (accept_mem | st_err_fire | ld_err_fire) begin
            buf_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (lsu_ready & new_request) begin
            buf_addr  <= rs1;
            buf_data  <= rs2;
            buf_fn3   <= fn3;
            buf_load  <= load;
            buf_store <= store;
            buf_id    <= id;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            seen_push <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr    <= (wr_ptr == PW'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr + PW'(1);
                seen_push <= 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PW'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_id[wr_ptr]  <= buf_id;
            q_fn3[wr_ptr] <= buf_fn3;
            q_off[wr_ptr] <= off;
        end
    end

    assign head_byte = mem_rdata[{q_off[rd_ptr], 3'b000} +: 8];
    assign head_half = mem_rdata[{q_off[rd_ptr][1], 4'b0000} +: 16];

    always_comb begin
        case (q_fn3[rd_ptr])
            3'b000:  ext_data = {{(XLEN-8){head_byte[7]}}, head_byte};
            3'b001:  ext_data = {{(XLEN-16){head_half[15]}}, head_half};
            3'b100:  ext_data = {{(XLEN-8){1'b0}}, head_byte};
            3'b101:  ext_data = {{(XLEN-16){1'b0}}, head_half};
            default: ext_data = mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lc_q   <= 1'b0;
            data_q <= '0;
            id_q   <= '0;
        end else begin
            lc_q <= pop;
            if (pop) begin
                data_q <= ext_data;
                id_q   <= q_id[rd_ptr];
            end
        end
    end

    // Stray read data after reset is tolerated until the next load is pushed.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(mem_rvalid && fifo_empty && seen_push));
        end
    end
endmodule

// File: tb/tb_rca_lsu_responder.sv
// Directed, table-driven bench for rca_lsu_responder.
// Single-request vectors in a table, multi-cycle corner cases by hand.
module tb_rca_lsu_responder;
    logic        clk = 1'b0;
    logic        rst;
    logic        new_request;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [2:0]  fn3;
    logic        load;
    logic        store;
    logic [3:0]  id;
    logic        lsu_ready;
    logic        load_complete;
    logic [31:0] load_data;
    logic [3:0]  load_id;
    logic        misaligned_error;
    logic        busy;
    logic        mem_request;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int n_cmp = 0;
    int n_err = 0;

    rca_lsu_responder #(
        .XLEN(32),
        .MAX_OUTSTANDING(4),
        .ID_W(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .new_request(new_request),
        .rs1(rs1),
        .rs2(rs2),
        .fn3(fn3),
        .load(load),
        .store(store),
        .id(id),
        .lsu_ready(lsu_ready),
        .load_complete(load_complete),
        .load_data(load_data),
        .load_id(load_id),
        .misaligned_error(misaligned_error),
        .busy(busy),
        .mem_request(mem_request),
        .mem_addr(mem_addr),
        .mem_we(mem_we),
        .mem_be(mem_be),
        .mem_wdata(mem_wdata),
        .mem_ack(mem_ack),
        .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ld;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        err;
        logic [3:0]  be;
        logic [31:0] wdat;
        logic [31:0] res;
    } vec_t;

    vec_t v[13];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [31:0] a, input logic [2:0] f,
                       input logic l, input logic s, input logic [3:0] t,
                       input logic [31:0] d);
        new_request = 1'b1;
        rs1 = a;
        fn3 = f;
        load = l;
        store = s;
        id = t;
        rs2 = d;
    endtask

    logic [3:0] tid;

    initial begin
        v[0]  = '{1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0,
                  1'b0, 4'hF, 32'hDEADBEEF, 32'h0};
        v[1]  = '{1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF,
                  1'b0, 4'hF, 32'h0, 32'hDEADBEEF};
        v[2]  = '{1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80123456,
                  1'b0, 4'hF, 32'h0, 32'hFFFFFF80};
        v[3]  = '{1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 32'h80123456,
                  1'b0, 4'hF, 32'h0, 32'h00000080};
        v[4]  = '{1'b0, 1'b1, 3'b001, 32'h102, 32'h00001234, 32'h0,
                  1'b0, 4'hC, 32'h12341234, 32'h0};
        v[5]  = '{1'b0, 1'b1, 3'b001, 32'h101, 32'h00001234, 32'h0,
                  1'b1, 4'h0, 32'h0, 32'h0};
        v[6]  = '{1'b0, 1'b1, 3'b000, 32'h101, 32'h000000AB, 32'h0,
                  1'b0, 4'h2, 32'hABABABAB, 32'h0};
        v[7]  = '{1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 32'h80017FFF,
                  1'b0, 4'hF, 32'h0, 32'hFFFF8001};
        v[8]  = '{1'b1, 1'b0, 3'b101, 32'h100, 32'h0, 32'h8001F00D,
                  1'b0, 4'hF, 32'h0, 32'h0000F00D};
        v[9]  = '{1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 32'h0,
                  1'b1, 4'h0, 32'h0, 32'h0};
        v[10] = '{1'b0, 1'b1, 3'b100, 32'h100, 32'h0, 32'h0,
                  1'b1, 4'h0, 32'h0, 32'h0};
        v[11] = '{1'b1, 1'b0, 3'b000, 32'h101, 32'h0, 32'h00007F00,
                  1'b0, 4'hF, 32'h0, 32'h0000007F};
        v[12] = '{1'b1, 1'b0, 3'b011, 32'h100, 32'h0, 32'h0,
                  1'b1, 4'h0, 32'h0, 32'h0};

        rst = 1'b1;
        new_request = 1'b0;
        rs1 = '0;
        rs2 = '0;
        fn3 = '0;
        load = 1'b0;
        store = 1'b0;
        id = '0;
        mem_ack = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata = '0;
        repeat (3) cyc;
        rst = 1'b0;
        #4;
        chk("rst lsu_ready", 32'(lsu_ready), 1);
        chk("rst load_complete", 32'(load_complete), 0);
        chk("rst load_data", load_data, 0);
        chk("rst load_id", 32'(load_id), 0);
        chk("rst misaligned", 32'(misaligned_error), 0);
        chk("rst busy", 32'(busy), 0);
        chk("rst mem_request", 32'(mem_request), 0);
        chk("rst mem_we", 32'(mem_we), 0);
        chk("rst mem_be", 32'(mem_be), 0);
        cyc;

        for (int i = 0; i < 13; i++) begin
            tid = 4'(i);
            req(v[i].addr, v[i].f3, v[i].ld, v[i].st, tid, v[i].wd);
            #4;
            chk($sformatf("v%0d ready", i), 32'(lsu_ready), 1);
            cyc;
            new_request = 1'b0;
            mem_ack = ~v[i].err;
            #4;
            if (v[i].err) begin
                chk($sformatf("v%0d err pulse", i), 32'(misaligned_error), 1);
                chk($sformatf("v%0d err no req", i), 32'(mem_request), 0);
                chk($sformatf("v%0d err lc", i), 32'(load_complete), 32'(v[i].ld));
                if (v[i].ld) begin
                    chk($sformatf("v%0d err data", i), load_data, 0);
                    chk($sformatf("v%0d err id", i), 32'(load_id), 32'(tid));
                end
            end else begin
                chk($sformatf("v%0d req", i), 32'(mem_request), 1);
                chk($sformatf("v%0d addr", i), mem_addr, v[i].addr & ~32'h3);
                chk($sformatf("v%0d we", i), 32'(mem_we), 32'(v[i].st));
                chk($sformatf("v%0d be", i), 32'(mem_be), 32'(v[i].be));
                chk($sformatf("v%0d no err", i), 32'(misaligned_error), 0);
                if (v[i].st)
                    chk($sformatf("v%0d wdata", i), mem_wdata, v[i].wdat);
            end
            cyc;
            mem_ack = 1'b0;
            if (!v[i].err && v[i].ld) begin
                mem_rvalid = 1'b1;
                mem_rdata = v[i].rd;
            end
            #4;
            chk($sformatf("v%0d lc early", i), 32'(load_complete), 0);
            cyc;
            mem_rvalid = 1'b0;
            #4;
            if (!v[i].err && v[i].ld) begin
                chk($sformatf("v%0d lc", i), 32'(load_complete), 1);
                chk($sformatf("v%0d data", i), load_data, v[i].res);
                chk($sformatf("v%0d id", i), 32'(load_id), 32'(tid));
            end else begin
                chk($sformatf("v%0d idle", i), 32'(busy), 0);
            end
            cyc;
        end

        // Five loads against a four-deep tracker.
        for (int k = 1; k <= 5; k++) begin
            req(32'h300 + 32'(4 * k), 3'b010, 1'b1, 1'b0, 4'(k), 32'h0);
            cyc;
            new_request = 1'b0;
            mem_ack = (k < 5);
            #4;
            chk($sformatf("full req%0d", k), 32'(mem_request), (k < 5) ? 1 : 0);
            cyc;
            mem_ack = 1'b0;
        end
        for (int k = 0; k < 2; k++) begin
            #4;
            chk("full hold", 32'(mem_request), 0);
            cyc;
        end
        mem_rvalid = 1'b1;
        mem_rdata = 32'hA0000001;
        mem_ack = 1'b1;
        #4;
        chk("full issue on pop", 32'(mem_request), 1);
        chk("full issue addr", mem_addr, 32'h314);
        cyc;
        mem_ack = 1'b0;
        for (int k = 2; k <= 5; k++) begin
            mem_rvalid = 1'b1;
            mem_rdata = 32'hA0000000 + 32'(k);
            #4;
            chk($sformatf("full lc%0d", k - 1), 32'(load_complete), 1);
            chk($sformatf("full data%0d", k - 1), load_data, 32'hA0000000 + 32'(k - 1));
            chk($sformatf("full id%0d", k - 1), 32'(load_id), 32'(k - 1));
            cyc;
        end
        mem_rvalid = 1'b0;
        #4;
        chk("full lc5", 32'(load_complete), 1);
        chk("full data5", load_data, 32'hA0000005);
        chk("full id5", 32'(load_id), 5);
        cyc;
        #4;
        chk("full drained", 32'(busy), 0);
        cyc;

        // Misaligned load queued behind two real loads.
        for (int k = 0; k < 2; k++) begin
            req(32'h400, 3'b010, 1'b1, 1'b0, 4'(6 + k), 32'h0);
            cyc;
            new_request = 1'b0;
            mem_ack = 1'b1;
            #4;
            chk("mis prior req", 32'(mem_request), 1);
            cyc;
            mem_ack = 1'b0;
        end
        req(32'h102, 3'b010, 1'b1, 1'b0, 4'd8, 32'h0);
        cyc;
        new_request = 1'b0;
        #4;
        chk("mis wait err", 32'(misaligned_error), 0);
        chk("mis wait lc", 32'(load_complete), 0);
        chk("mis wait req", 32'(mem_request), 0);
        cyc;
        #4;
        chk("mis wait lc2", 32'(load_complete), 0);
        cyc;
        mem_rvalid = 1'b1;
        mem_rdata = 32'h11111111;
        #4;
        cyc;
        mem_rdata = 32'h22222222;
        #4;
        chk("mis lc6", 32'(load_complete), 1);
        chk("mis id6", 32'(load_id), 6);
        chk("mis data6", load_data, 32'h11111111);
        cyc;
        mem_rvalid = 1'b0;
        #4;
        chk("mis lc7", 32'(load_complete), 1);
        chk("mis id7", 32'(load_id), 7);
        chk("mis data7", load_data, 32'h22222222);
        chk("mis err early", 32'(misaligned_error), 0);
        cyc;
        #4;
        chk("mis lc8", 32'(load_complete), 1);
        chk("mis err8", 32'(misaligned_error), 1);
        chk("mis data8", load_data, 0);
        chk("mis id8", 32'(load_id), 8);
        cyc;
        #4;
        chk("mis idle", 32'(busy), 0);
        cyc;

        // Reset with three loads outstanding, then stray read data.
        for (int k = 0; k < 3; k++) begin
            req(32'h500, 3'b010, 1'b1, 1'b0, 4'(9 + k), 32'h0);
            cyc;
            new_request = 1'b0;
            mem_ack = 1'b1;
            cyc;
            mem_ack = 1'b0;
        end
        #4;
        chk("rip busy", 32'(busy), 1);
        cyc;
        rst = 1'b1;
        cyc;
        rst = 1'b0;
        #4;
        chk("rip busy after", 32'(busy), 0);
        chk("rip ready after", 32'(lsu_ready), 1);
        chk("rip lc after", 32'(load_complete), 0);
        cyc;
        for (int k = 0; k < 3; k++) begin
            mem_rvalid = 1'b1;
            mem_rdata = 32'hBAD00000 + 32'(k);
            #4;
            chk("rip stray lc", 32'(load_complete), 0);
            cyc;
        end
        mem_rvalid = 1'b0;
        #4;
        chk("rip stray lc end", 32'(load_complete), 0);
        chk("rip stray busy", 32'(busy), 0);
        cyc;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
